wb_arbiter: RTL and testbench

Writeback arbiter and scoreboard for the 16-entry register file. Accepts results from three producers (ALU, load return, multiplier) over valid/ready handshakes and maps them onto the register file's two write ports (`w_*1` and `w_*_ldr`). R15 results are diverted to a PC redirect path. A per-register pending scoreboard drives operand-hazard stalls for the decoder.

---
 rtl/wb_pkg.sv | 46 ++++
 rtl/wb_scoreboard.sv | 48 ++++
 rtl/wb_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_wb_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types, widths and helpers for the writeback arbiter.
package wb_pkg;

    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned NUM_REGS    = 16;
    localparam int unsigned NUM_TRACKED = 15;

    localparam logic [ADDR_W-1:0] REG_PC = 4'd15;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_MUL = 2'd2
    } wb_src_e;

    // One-hot register vector with the addressed bit set when en is high.
    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic en,
                                                        input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        vec       = '0;
        vec[addr] = en;
        return vec;
    endfunction

    // Select one of the three producer requests.
    function automatic wb_req_t wb_pick(input wb_src_e src,
                                        input wb_req_t alu,
                                        input wb_req_t mem,
                                        input wb_req_t mul);
        wb_req_t sel;
        case (src)
            SRC_MEM: sel = mem;
            SRC_MUL: sel = mul;
            default: sel = alu;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending bits for R0..R14, reservation stall
// and the pending half of the operand hazard.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic [NUM_REGS-1:0] clr_vec,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic                issue_stall,
    output logic                hazard_pend_c
);

    logic [NUM_TRACKED-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0]    pend_ext;
    logic                   issue_trk;
    logic                   unused_clr;

    // R15 is never tracked, so its slot in the extended view reads as clear.
    assign pend_ext   = {1'b0, pending_q};
    assign issue_trk  = issue_valid && (issue_addr != REG_PC);
    assign unused_clr = clr_vec[NUM_REGS-1];

    // A reservation is refused only if the bit stays set through this edge.
    assign issue_stall   = issue_trk && pend_ext[issue_addr] && !clr_vec[issue_addr];
    assign hazard_pend_c = pend_ext[rd_addr_a] || pend_ext[rd_addr_b];

    // Clear granted registers first so a same-cycle reservation wins.
    always_comb begin
        pending_d = pending_q & ~clr_vec[NUM_TRACKED-1:0];
        if (issue_trk && !issue_stall) begin
            pending_d[issue_addr] = 1'b1;
        end
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: maps ALU, load-return and multiplier results onto the two
// register-file write ports, diverts R15 results to a PC redirect, and
// tracks pending destinations for decoder hazard stalls.
// Build option: WB_MUL_EN enables the multiplier source and its starvation
// counter; without it mul_ready is tied low and mul_* inputs are ignored.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned PC_W         = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mul_valid,
    output logic              mul_ready,
    input  logic [ADDR_W-1:0] mul_addr,
    input  logic [DATA_W-1:0] mul_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_stall,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              hazard,
    output logic              w_en1,
    output logic [ADDR_W-1:0] w_addr1,
    output logic [DATA_W-1:0] w_data1,
    output logic              w_en_ldr,
    output logic [ADDR_W-1:0] w_addr_ldr,
    output logic [DATA_W-1:0] w_data_ldr,
    output logic              pc_redirect,
    output logic [PC_W-1:0]   pc_target
);

    wb_req_t alu_req, mem_req, mul_req;
    logic    alu_wr, mem_wr, mul_wr;
    logic    alu_pc, mem_pc, mul_pc;
    logic    mul_forced;
    logic    gnt_alu_wr, gnt_mem_wr, gnt_mul_p1, gnt_mul_ldr;
    logic    gnt_alu_pc, gnt_mem_pc, gnt_mul_pc, gnt_pc;
    wb_src_e pc_src, p1_src, ldr_src;
    logic    p1_en, ldr_en;
    wb_req_t p1_req, ldr_req, pc_req;
    logic [NUM_REGS-1:0] clr_vec;
    logic    hazard_pend_c;

    logic              w_en1_q, w_en1_d;
    logic [ADDR_W-1:0] w_addr1_q, w_addr1_d;
    logic [DATA_W-1:0] w_data1_q, w_data1_d;
    logic              w_en_ldr_q, w_en_ldr_d;
    logic [ADDR_W-1:0] w_addr_ldr_q, w_addr_ldr_d;
    logic [DATA_W-1:0] w_data_ldr_q, w_data_ldr_d;
    logic              pc_redirect_q, pc_redirect_d;
    logic [PC_W-1:0]   pc_target_q, pc_target_d;

    assign alu_req = {alu_valid, alu_addr, alu_data};
    assign mem_req = {mem_valid, mem_addr, mem_data};

`ifdef WB_MUL_EN
    assign mul_req = {mul_valid, mul_addr, mul_data};
`else
    logic unused_mul;
    assign mul_req    = '0;
    assign unused_mul = ^{mul_valid, mul_addr, mul_data, 32'(STARVE_LIMIT)};
`endif

    // Split each request into the redirect path (R15) or a write-port request.
    assign alu_pc = alu_req.valid && (alu_req.addr == REG_PC);
    assign mem_pc = mem_req.valid && (mem_req.addr == REG_PC);
    assign mul_pc = mul_req.valid && (mul_req.addr == REG_PC);
    assign alu_wr = alu_req.valid && (alu_req.addr != REG_PC);
    assign mem_wr = mem_req.valid && (mem_req.addr != REG_PC);
    assign mul_wr = mul_req.valid && (mul_req.addr != REG_PC);

    // Write-port grants; address collisions defer mem > forced mul > ALU > mul.
    // An ALU R15 request leaves port 1 free for the multiplier.
    always_comb begin
        gnt_mem_wr  = mem_wr;
        gnt_alu_wr  = 1'b0;
        gnt_mul_p1  = 1'b0;
        gnt_mul_ldr = 1'b0;
        if (mul_forced) begin
            gnt_mul_p1 = !(mem_wr && (mem_req.addr == mul_req.addr));
        end else begin
            gnt_alu_wr = alu_wr && !(mem_wr && (mem_req.addr == alu_req.addr));
            if (mul_wr && !alu_wr) begin
                gnt_mul_p1 = !(mem_wr && (mem_req.addr == mul_req.addr));
            end else if (mul_wr && !mem_wr) begin
                gnt_mul_ldr = (alu_req.addr != mul_req.addr);
            end
        end
    end

    // Single redirect slot per cycle, ALU > mem > mul.
    always_comb begin
        gnt_alu_pc = alu_pc;
        gnt_mem_pc = mem_pc && !alu_pc;
        gnt_mul_pc = mul_pc && !alu_pc && !mem_pc;
        gnt_pc     = alu_pc || mem_pc || mul_pc;
        pc_src     = SRC_ALU;
        if (gnt_mem_pc) begin
            pc_src = SRC_MEM;
        end else if (gnt_mul_pc) begin
            pc_src = SRC_MUL;
        end
    end

    assign alu_ready = gnt_alu_wr || gnt_alu_pc;
    assign mem_ready = gnt_mem_wr || gnt_mem_pc;

`ifdef WB_MUL_EN
    localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign mul_ready  = gnt_mul_p1 || gnt_mul_ldr || gnt_mul_pc;
    assign mul_forced = mul_wr && (starve_q == CNT_MAX);

    // Count denied write-port cycles; saturate at the limit, clear on any grant.
    always_comb begin
        starve_d = starve_q;
        if (mul_ready) begin
            starve_d = '0;
        end else if (mul_wr && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign mul_ready  = 1'b0;
    assign mul_forced = 1'b0;
`endif

    assign p1_en   = gnt_alu_wr || gnt_mul_p1;
    assign ldr_en  = gnt_mem_wr || gnt_mul_ldr;
    assign p1_src  = gnt_mul_p1  ? SRC_MUL : SRC_ALU;
    assign ldr_src = gnt_mul_ldr ? SRC_MUL : SRC_MEM;
    assign p1_req  = wb_pick(p1_src,  alu_req, mem_req, mul_req);
    assign ldr_req = wb_pick(ldr_src, alu_req, mem_req, mul_req);
    assign pc_req  = wb_pick(pc_src,  alu_req, mem_req, mul_req);
    assign clr_vec = addr_onehot(p1_en, p1_req.addr) | addr_onehot(ldr_en, ldr_req.addr);

    // Output-stage next state; addr/data/target hold when nothing is granted.
    always_comb begin
        w_en1_d       = p1_en;
        w_addr1_d     = w_addr1_q;
        w_data1_d     = w_data1_q;
        w_en_ldr_d    = ldr_en;
        w_addr_ldr_d  = w_addr_ldr_q;
        w_data_ldr_d  = w_data_ldr_q;
        pc_redirect_d = gnt_pc;
        pc_target_d   = pc_target_q;
        if (p1_en) begin
            w_addr1_d = p1_req.addr;
            w_data1_d = p1_req.data;
        end
        if (ldr_en) begin
            w_addr_ldr_d = ldr_req.addr;
            w_data_ldr_d = ldr_req.data;
        end
        if (gnt_pc) begin
            pc_target_d = pc_req.data[PC_W-1:0];
        end
    end

    // Output-stage registers; reset drops any in-flight write immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en1_q       <= 1'b0;
            w_addr1_q     <= '0;
            w_data1_q     <= '0;
            w_en_ldr_q    <= 1'b0;
            w_addr_ldr_q  <= '0;
            w_data_ldr_q  <= '0;
            pc_redirect_q <= 1'b0;
            pc_target_q   <= '0;
        end else begin
            w_en1_q       <= w_en1_d;
            w_addr1_q     <= w_addr1_d;
            w_data1_q     <= w_data1_d;
            w_en_ldr_q    <= w_en_ldr_d;
            w_addr_ldr_q  <= w_addr_ldr_d;
            w_data_ldr_q  <= w_data_ldr_d;
            pc_redirect_q <= pc_redirect_d;
            pc_target_q   <= pc_target_d;
        end
    end

    assign w_en1       = w_en1_q;
    assign w_addr1     = w_addr1_q;
    assign w_data1     = w_data1_q;
    assign w_en_ldr    = w_en_ldr_q;
    assign w_addr_ldr  = w_addr_ldr_q;
    assign w_data_ldr  = w_data_ldr_q;
    assign pc_redirect = pc_redirect_q;
    assign pc_target   = pc_target_q;

    wb_scoreboard u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_addr    (issue_addr),
        .clr_vec       (clr_vec),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .issue_stall   (issue_stall),
        .hazard_pend_c (hazard_pend_c)
    );

    // Operand hazard: pending, or being written by the output stage right now.
    assign hazard = hazard_pend_c
                 || (w_en1_q    && ((w_addr1_q    == rd_addr_a) || (w_addr1_q    == rd_addr_b)))
                 || (w_en_ldr_q && ((w_addr_ldr_q == rd_addr_a) || (w_addr_ldr_q == rd_addr_b)));

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized producers, checked
// against a priority-walk reference model of the arbiter and scoreboard.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned STARVE_LIMIT = 3;
    localparam int unsigned PC_W         = 11;
`ifdef WB_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, mul_valid, issue_valid;
    logic        alu_ready, mem_ready, mul_ready, issue_stall, hazard;
    logic [3:0]  alu_addr, mem_addr, mul_addr, issue_addr, rd_addr_a, rd_addr_b;
    logic [31:0] alu_data, mem_data, mul_data;
    logic        w_en1, w_en_ldr, pc_redirect;
    logic [3:0]  w_addr1, w_addr_ldr;
    logic [31:0] w_data1, w_data_ldr;
    logic [PC_W-1:0] pc_target;

    wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_addr(mul_addr), .mul_data(mul_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_stall(issue_stall),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard(hazard),
        .w_en1(w_en1), .w_addr1(w_addr1), .w_data1(w_data1),
        .w_en_ldr(w_en_ldr), .w_addr_ldr(w_addr_ldr), .w_data_ldr(w_data_ldr),
        .pc_redirect(pc_redirect), .pc_target(pc_target)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model state
    logic [15:0]     m_pend;
    int unsigned     m_starve;
    logic            e_en1, e_enl, e_pc;
    logic [3:0]      e_a1, e_al;
    logic [31:0]     e_d1, e_dl;
    logic [PC_W-1:0] e_tgt;
    bit              m_ga, m_gm, m_gu;
    logic [31:0]     rf [16];

    task automatic model_reset();
        m_pend = '0; m_starve = 0;
        e_en1 = 0; e_enl = 0; e_pc = 0;
        e_a1 = '0; e_al = '0; e_d1 = '0; e_dl = '0; e_tgt = '0;
        m_ga = 0; m_gm = 0; m_gu = 0;
    endtask

    task automatic idle();
        alu_valid = 0; alu_addr = '0; alu_data = '0;
        mem_valid = 0; mem_addr = '0; mem_data = '0;
        mul_valid = 0; mul_addr = '0; mul_data = '0;
        issue_valid = 0; issue_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    endtask

    // One cycle: inputs already settled. Check handshakes, clock, check outputs.
    task automatic step();
        bit aw, ap, mw, mp, uw, up, forced, ga, gm, gu, stall, hz;
        int p1, ld, pcs;
        logic [15:0] used;
        logic [31:0] pcd;
        aw = alu_valid && alu_addr != 4'd15;  ap = alu_valid && alu_addr == 4'd15;
        mw = mem_valid && mem_addr != 4'd15;  mp = mem_valid && mem_addr == 4'd15;
        uw = MUL_EN && mul_valid && mul_addr != 4'd15;
        up = MUL_EN && mul_valid && mul_addr == 4'd15;
        forced = uw && (m_starve == STARVE_LIMIT);
        ga = 0; gm = 0; gu = 0; p1 = -1; ld = -1; pcs = -1; used = '0; pcd = '0;
        // redirect slot
        if (ap) begin pcs = 0; ga = 1; pcd = alu_data; end
        else if (mp) begin pcs = 1; gm = 1; pcd = mem_data; end
        else if (up) begin pcs = 2; gu = 1; pcd = mul_data; end
        // write ports, walked in priority order, each register claimed once
        if (mw) begin gm = 1; ld = 1; used[mem_addr] = 1; end
        if (forced && !used[mul_addr]) begin gu = 1; p1 = 2; used[mul_addr] = 1; end
        if (aw && !forced && !used[alu_addr]) begin ga = 1; p1 = 0; used[alu_addr] = 1; end
        if (uw && !forced && !used[mul_addr]) begin
            if (!aw) begin gu = 1; p1 = 2; end
            else if (!mw) begin gu = 1; ld = 2; end
        end
        stall = issue_valid && issue_addr != 4'd15 && m_pend[issue_addr] && !used[issue_addr];
        hz = m_pend[rd_addr_a] || m_pend[rd_addr_b]
          || (e_en1 && (e_a1 == rd_addr_a || e_a1 == rd_addr_b))
          || (e_enl && (e_al == rd_addr_a || e_al == rd_addr_b));
        check("alu_ready", 32'(alu_ready), 32'(ga));
        check("mem_ready", 32'(mem_ready), 32'(gm));
        check("mul_ready", 32'(mul_ready), 32'(gu));
        check("issue_stall", 32'(issue_stall), 32'(stall));
        check("hazard", 32'(hazard), 32'(hz));
        if (w_en1) rf[w_addr1] = w_data1;
        if (w_en_ldr) rf[w_addr_ldr] = w_data_ldr;
        @(posedge clk);
        m_pend = m_pend & ~used;
        if (issue_valid && issue_addr != 4'd15 && !stall) m_pend[issue_addr] = 1'b1;
        if (gu) m_starve = 0;
        else if (uw && m_starve < STARVE_LIMIT) m_starve++;
        e_en1 = (p1 >= 0);
        if (p1 == 0) begin e_a1 = alu_addr; e_d1 = alu_data; end
        if (p1 == 2) begin e_a1 = mul_addr; e_d1 = mul_data; end
        e_enl = (ld >= 0);
        if (ld == 1) begin e_al = mem_addr; e_dl = mem_data; end
        if (ld == 2) begin e_al = mul_addr; e_dl = mul_data; end
        e_pc = (pcs >= 0);
        if (e_pc) e_tgt = pcd[PC_W-1:0];
        m_ga = ga; m_gm = gm; m_gu = gu;
        #1;
        check("w_en1", 32'(w_en1), 32'(e_en1));
        if (e_en1) begin
            check("w_addr1", 32'(w_addr1), 32'(e_a1));
            check("w_data1", w_data1, e_d1);
        end
        check("w_en_ldr", 32'(w_en_ldr), 32'(e_enl));
        if (e_enl) begin
            check("w_addr_ldr", 32'(w_addr_ldr), 32'(e_al));
            check("w_data_ldr", w_data_ldr, e_dl);
        end
        check("pc_redirect", 32'(pc_redirect), 32'(e_pc));
        if (e_pc) check("pc_target", 32'(pc_target), 32'(e_tgt));
        @(negedge clk);
    endtask

    function automatic logic [3:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 4'd15;
        if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(0, 14));
    endfunction

    initial begin
        for (int r = 0; r < 16; r++) rf[r] = '0;
        idle();
        model_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rd_addr_a = 4'd3; rd_addr_b = 4'd4;
        #1;
        check("rst_w_en1", 32'(w_en1), 32'd0);
        check("rst_w_en_ldr", 32'(w_en_ldr), 32'd0);
        check("rst_w_data1", w_data1, 32'd0);
        check("rst_pc_redirect", 32'(pc_redirect), 32'd0);
        check("rst_hazard", 32'(hazard), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // ALU R3 and load R4 in the same cycle
        alu_valid = 1; alu_addr = 4'd3; alu_data = 32'h11;
        mem_valid = 1; mem_addr = 4'd4; mem_data = 32'h22;
        #1;
        step();
        check("dual_addr1", 32'(w_addr1), 32'd3);
        check("dual_data_ldr", w_data_ldr, 32'h22);
        idle(); #1; step();

`ifdef WB_MUL_EN
        // Starvation: multiplier denied STARVE_LIMIT cycles, then forced onto port 1
        mul_valid = 1; mul_addr = 4'd9; mul_data = 32'h9999;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_addr = 4'(i + 1); alu_data = $urandom;
            mem_valid = 1; mem_addr = 4'(i + 5); mem_data = $urandom;
            #1;
            check("starve_mul_ready", 32'(mul_ready), 32'(i == 3));
            check("starve_alu_ready", 32'(alu_ready), 32'(i != 3));
            step();
        end
        check("forced_addr1", 32'(w_addr1), 32'd9);
        mul_addr = 4'd10; alu_addr = 4'd4; mem_addr = 4'd11;
        #1;
        check("starve_cleared", 32'(mul_ready), 32'd0);
        step();
        idle(); #1; step();
`endif

        // Same-address: load wins, ALU deferred one cycle
        alu_valid = 1; alu_addr = 4'd5; alu_data = 32'hAAAA_0005;
        mem_valid = 1; mem_addr = 4'd5; mem_data = 32'hBBBB_0005;
        #1;
        check("same_alu_deferred", 32'(alu_ready), 32'd0);
        step();
        mem_valid = 0; #1;
        step();
        idle(); #1;
        step();
        check("same_r5_final", rf[5], 32'hAAAA_0005);

        // R15 redirect, ALU beats load for the single slot
        alu_valid = 1; alu_addr = 4'd15; alu_data = 32'h0000_0123;
        mem_valid = 1; mem_addr = 4'd15; mem_data = 32'h0000_0456;
        #1;
        step();
        check("r15_target", 32'(pc_target), 32'h123);
        check("r15_no_write", 32'(w_en1), 32'd0);
        alu_valid = 0; #1;
        step();
        idle(); #1;
        step();
        check("r15_pulse_end", 32'(pc_redirect), 32'd0);

        // Scoreboard: reserve R2, re-issue stalls, load clears, hazard lingers one cycle
        issue_valid = 1; issue_addr = 4'd2; #1;
        step();
        issue_valid = 0; rd_addr_a = 4'd2; #1;
        check("sb_hazard_pend", 32'(hazard), 32'd1);
        issue_valid = 1; #1;
        check("sb_reissue_stall", 32'(issue_stall), 32'd1);
        step();
        issue_valid = 0; mem_valid = 1; mem_addr = 4'd2; mem_data = 32'h2222; #1;
        step();
        mem_valid = 0; #1;
        check("sb_hazard_inflight", 32'(hazard), 32'd1);
        step();
        check("sb_hazard_clear", 32'(hazard), 32'd0);
        // Issue and grant to the same register: the reservation survives
        issue_valid = 1; issue_addr = 4'd6; #1;
        step();
        mem_valid = 1; mem_addr = 4'd6; mem_data = 32'h6666; #1;
        step();
        idle(); rd_addr_a = 4'd6; #1;
        step();
        check("sb_set_wins", 32'(hazard), 32'd1);

        // Reset while the output stage holds a write
        idle();
        alu_valid = 1; alu_addr = 4'd7; alu_data = 32'h7777;
        issue_valid = 1; issue_addr = 4'd8; #1;
        step();
        idle(); rd_addr_a = 4'd8; rd_addr_b = 4'd6; #1;
        check("pre_rst_en1", 32'(w_en1), 32'd1);
        rst_n = 0;
        #1;
        check("async_rst_en1", 32'(w_en1), 32'd0);
        check("async_rst_en_ldr", 32'(w_en_ldr), 32'd0);
        check("async_rst_pending", 32'(hazard), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        #1;

        // Randomized producers honouring valid/ready hold rules
        for (int c = 0; c < 1500; c++) begin
            if (!alu_valid || m_ga) begin
                alu_valid = ($urandom_range(0, 3) != 0); alu_addr = rand_addr(); alu_data = $urandom;
            end
            if (!mem_valid || m_gm) begin
                mem_valid = ($urandom_range(0, 3) != 0); mem_addr = rand_addr(); mem_data = $urandom;
            end
            if (!mul_valid || m_gu) begin
                mul_valid = ($urandom_range(0, 2) != 0); mul_addr = rand_addr(); mul_data = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_addr  = rand_addr();
            rd_addr_a   = 4'($urandom_range(0, 15));
            rd_addr_b   = 4'($urandom_range(0, 15));
            #1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
